// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces two coin sensors, queues coin codes in a 4-deep FIFO and emits them to the vending FSM.
// Ports: clk, rst (async active-high); coin5_sns/coin10_sns raw sensors; inhibit rejects new coins;
// x coin code (01 five, 10 ten) for one cycle per coin; reject one-cycle pulse per rejected coin;
// busy while coins queued or emitting; fifo_cnt queue occupancy 0..4.
// Optional macro COIN_TOTAL_EN adds total_clr input and coin_total output (accepted value in 5-unit steps, saturating).
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin5_sns,
  input  logic       coin10_sns,
  input  logic       inhibit,
`ifdef COIN_TOTAL_EN
  input  logic       total_clr,
  output logic [7:0] coin_total,
`endif
  output logic [1:0] x,
  output logic       reject,
  output logic       busy,
  output logic [2:0] fifo_cnt
);
  localparam logic [1:0] IDLE = 2'd0, EMIT = 2'd1, GAP = 2'd2;
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [1:0] ev;
  logic [1:0] state;
  logic [1:0] mem [4];
  logic [1:0] wp, rp, code;
  logic pop, push, rej;
  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic meta, sync, lvl;
    logic [7:0] dcnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        meta <= 1'b0;
        sync <= 1'b0;
        lvl  <= 1'b0;
        dcnt <= '0;
      end else begin
        meta <= i == 0 ? coin5_sns : coin10_sns;
        sync <= meta;
        if (sync == lvl) dcnt <= '0;
        else if (dcnt == LAST) begin
          dcnt <= '0;
          lvl  <= sync;
        end else dcnt <= dcnt + 8'd1;
      end
    // Event fires in the cycle whose closing edge raises the debounced level.
    assign ev[i] = sync & ~lvl & (dcnt == LAST);
  end
  always_comb begin
    pop  = (state == IDLE) & (fifo_cnt != 3'd0);
    push = (^ev) & ~inhibit & ((fifo_cnt != 3'd4) | pop);
    rej  = (&ev) | ((^ev) & ~push);
    code = ev[0] ? 2'b01 : 2'b10;
  end
  assign busy = (fifo_cnt != 3'd0) | (state != IDLE);
  always_ff @(posedge clk)
    if (push) mem[wp] <= code;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      fifo_cnt <= '0;
      state    <= IDLE;
      x        <= 2'b00;
      reject   <= 1'b0;
    end else begin
      wp       <= wp + 2'(push);
      rp       <= rp + 2'(pop);
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
      state    <= state == IDLE ? (pop ? EMIT : IDLE) : state == EMIT ? GAP : IDLE;
      x        <= pop ? mem[rp] : 2'b00;
      reject   <= rej;
    end
`ifdef COIN_TOTAL_EN
  logic [8:0] sum;
  assign sum = 9'(coin_total) + (ev[1] ? 9'd2 : 9'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) coin_total <= '0;
    else if (total_clr) coin_total <= '0;
    else if (push) coin_total <= sum[8] ? 8'hFF : sum[7:0];
`endif
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed vectors and corner-case sequences for coin_acceptor.
module tb_coin_acceptor;
  logic clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  logic a5 = 1'b0, a10 = 1'b0, ainh = 1'b0, b5 = 1'b0, b10 = 1'b0, binh = 1'b0;
  logic [1:0] ax, bx;
  logic arej, brej, abusy, bbusy;
  logic [2:0] afc, bfc;
`ifdef COIN_TOTAL_EN
  logic aclr = 1'b0, bclr = 1'b0;
  logic [7:0] atot, btot;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  coin_acceptor #(.DEBOUNCE_CYCLES(16)) u_a (
    .clk(clk), .rst(rst_a), .coin5_sns(a5), .coin10_sns(a10), .inhibit(ainh),
`ifdef COIN_TOTAL_EN
    .total_clr(aclr), .coin_total(atot),
`endif
    .x(ax), .reject(arej), .busy(abusy), .fifo_cnt(afc));
  coin_acceptor #(.DEBOUNCE_CYCLES(2)) u_b (
    .clk(clk), .rst(rst_b), .coin5_sns(b5), .coin10_sns(b10), .inhibit(binh),
`ifdef COIN_TOTAL_EN
    .total_clr(bclr), .coin_total(btot),
`endif
    .x(bx), .reject(brej), .busy(bbusy), .fifo_cnt(bfc));
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    string nm;
    int c5h;
    int c10h;
    bit inh;
    int n5;
    int n10;
    int nrej;
  } vec_t;
  vec_t v[7];
  int n5, n10, nr, gapv, bad, maxfc, np, n, seen;
  int codes[8];
  logic [1:0] px;
  logic [2:0] pfc;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{"c5_40", 40, 0, 1'b0, 1, 0, 0};
    v[1] = '{"c10_glitch10", 0, 10, 1'b0, 0, 0, 0};
    v[2] = '{"c10_40", 0, 40, 1'b0, 0, 1, 0};
    v[3] = '{"jam_30", 30, 30, 1'b0, 0, 0, 1};
    v[4] = '{"inhibit_c5", 40, 0, 1'b1, 0, 0, 1};
    v[5] = '{"c5_16_exact", 16, 0, 1'b0, 1, 0, 0};
    v[6] = '{"c5_15_short", 15, 0, 1'b0, 0, 0, 0};
    repeat (3) tick();
    chk("rst_a_x", ax, 0); chk("rst_a_rej", arej, 0); chk("rst_a_busy", abusy, 0); chk("rst_a_fc", afc, 0);
    chk("rst_b_x", bx, 0); chk("rst_b_busy", bbusy, 0); chk("rst_b_fc", bfc, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      n5 = 0; n10 = 0; nr = 0; gapv = 0; px = 2'b00;
      for (int c = 0; c < 80; c++) begin
        a5 = c < v[k].c5h; a10 = c < v[k].c10h; ainh = v[k].inh;
        tick();
        n5 += int'(ax == 2'b01); n10 += int'(ax == 2'b10); nr += int'(arej);
        if ((ax != 0 && px != 0) || ax == 2'b11) gapv++;
        px = ax;
      end
      ainh = 1'b0;
      chk({v[k].nm, "_n5"}, n5, v[k].n5);
      chk({v[k].nm, "_n10"}, n10, v[k].n10);
      chk({v[k].nm, "_rej"}, nr, v[k].nrej);
      chk({v[k].nm, "_gap"}, gapv, 0);
      chk({v[k].nm, "_fc"}, afc, 0);
      chk({v[k].nm, "_busy"}, abusy, 0);
    end
    // Latency: push edge N, code on x only after edge N+1, then one GAP cycle.
    a5 = 1'b1; n = 0;
    do begin tick(); n++; end while (afc != 1 && n < 40);
    chk("lat_push", afc, 1); chk("lat_x_n", ax, 0);
    tick(); chk("lat_x_n1", ax, 1); chk("lat_busy_emit", abusy, 1); chk("lat_fc_pop", afc, 0);
    tick(); chk("lat_x_gap", ax, 0); chk("lat_busy_gap", abusy, 1);
    tick(); chk("lat_busy_idle", abusy, 0);
    a5 = 1'b0;
    repeat (40) tick();
    // Sensor held high through a reset yields exactly one coin afterwards.
    a5 = 1'b1;
    repeat (5) tick();
    rst_a = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0; n5 = 0;
    for (int c = 0; c < 50; c++) begin tick(); n5 += int'(ax == 2'b01); end
    chk("held_rst_n5", n5, 1);
    a5 = 1'b0;
    repeat (40) tick();
    // Overflow on the fast-debounce instance: rejects only while full.
    np = 0; nr = 0; bad = 0; maxfc = 0; gapv = 0; px = 2'b00; pfc = 3'd0;
    for (int c = 0; c < 80; c++) begin
      b5 = c < 40 && (c % 4) < 2; b10 = c >= 2 && c < 42 && ((c - 2) % 4) < 2;
      tick();
      np += int'(bx != 0); nr += int'(brej);
      if (brej && pfc != 3'd4) bad++;
      if (int'(bfc) > maxfc) maxfc = int'(bfc);
      if ((bx != 0 && px != 0) || bx == 2'b11) gapv++;
      px = bx; pfc = bfc;
    end
    chk("ovf_total", np + nr, 20); chk("ovf_rej_seen", int'(nr > 0), 1); chk("ovf_max_fc", maxfc, 4);
    chk("ovf_rej_when_full", bad, 0); chk("ovf_gap", gapv, 0); chk("ovf_fc_end", bfc, 0);
    // Inhibited coin10 while earlier coins are queued.
    np = 0; nr = 0;
    for (int c = 0; c < 40; c++) begin
      b5 = c < 2 || (c >= 4 && c < 6); b10 = (c >= 2 && c < 4) || (c >= 8 && c < 10); binh = c >= 9 && c < 16;
      tick();
      nr += int'(brej);
      if (bx != 0) begin if (np < 8) codes[np] = int'(bx); np++; end
    end
    binh = 1'b0;
    chk("inh_rej", nr, 1); chk("inh_ncodes", np, 3);
    chk("inh_code0", codes[0], 1); chk("inh_code1", codes[1], 2); chk("inh_code2", codes[2], 1);
    // Asynchronous reset with three coins queued.
    seen = 0;
    for (int c = 0; c < 60 && seen == 0; c++) begin
      b5 = (c % 4) < 2; b10 = c >= 2 && ((c - 2) % 4) < 2;
      tick();
      if (bfc == 3'd3) seen = 1;
    end
    chk("arst_reached3", seen, 1);
    b5 = 1'b0; b10 = 1'b0;
    #2 rst_b = 1'b1;
    #1;
    chk("arst_x", bx, 0); chk("arst_fc", bfc, 0); chk("arst_busy", bbusy, 0); chk("arst_rej", brej, 0);
    tick();
    rst_b = 1'b0; np = 0; nr = 0;
    for (int c = 0; c < 30; c++) begin tick(); np += int'(bx != 0); nr += int'(brej); end
    chk("arst_no_x", np, 0); chk("arst_no_rej", nr, 0);
`ifdef COIN_TOTAL_EN
    bclr = 1'b1; tick(); bclr = 1'b0;
    chk("tot_clr", btot, 0);
    for (int k = 0; k < 140; k++) begin
      for (int c = 0; c < 4; c++) begin b10 = c < 2; tick(); end
      if (k == 9) begin repeat (4) tick(); chk("tot_10_tens", btot, 20); end
    end
    repeat (6) tick();
    chk("tot_sat", btot, 255);
    bclr = 1'b1; tick(); bclr = 1'b0;
    chk("tot_clr2", btot, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
